cpu_store_buffer: RTL

CPU_STORE_BUFFER -- requirements
Module: cpu_store_buffer

---
 rtl/cpu_store_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/cpu_store_buffer.sv
// cpu_store_buffer: posted-write FIFO between writeback and a Wishbone bus.
// Stores are queued and retired in order, one bus write per entry.
module cpu_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memory_write_enable_i,
  input  logic [31:0] memory_write_address_i,
  input  logic [31:0] memory_write_value_i,
  output logic        stall_o,
  output logic        empty_o,
  output logic        overflow_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C1   = (AW+1)'(1);
  localparam logic [AW-1:0] P1   = AW'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q;
  logic [31:0]   adr_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full;
  logic          push;
  logic          pop;

  assign full   = (cnt_q == FULL);
  assign push   = memory_write_enable_i && !full;
  assign pop    = (state_q == REQ) && wb_ack_i;
  assign rd_nxt = rd_ptr_q + P1;

  assign stall_o  = full;
  assign empty_o  = (cnt_q == '0) && (state_q == IDLE);
  assign wb_cyc_o = (state_q == REQ);
  assign wb_stb_o = (state_q == REQ);
  assign wb_we_o  = (state_q == REQ);
  assign wb_sel_o = (state_q == REQ) ? 4'hF : 4'h0;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + C1;
    else if (!push && pop) cnt_d = cnt_q - C1;
  end

  // Entry storage; contents are meaningless outside the live window.
  always_ff @(posedge clk_i) begin
    if (push) begin
      adr_mem[wr_ptr_q] <= memory_write_address_i;
      dat_mem[wr_ptr_q] <= memory_write_value_i;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + P1;
      if (pop) rd_ptr_q <= rd_nxt;
      if (memory_write_enable_i && full) overflow_o <= 1'b1;
    end
  end

  // Bus FSM; the head entry is latched into the address/data registers.
  // When the last entry retires while a new one arrives, the new entry
  // is not in the array yet, so it is taken straight from the inputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            state_q  <= REQ;
            wb_adr_o <= adr_mem[rd_ptr_q];
            wb_dat_o <= dat_mem[rd_ptr_q];
          end
        end
        REQ: begin
          if (wb_ack_i) begin
            if (cnt_d == '0) begin
              state_q <= IDLE;
            end else if (cnt_q == C1) begin
              wb_adr_o <= memory_write_address_i;
              wb_dat_o <= memory_write_value_i;
            end else begin
              wb_adr_o <= adr_mem[rd_nxt];
              wb_dat_o <= dat_mem[rd_nxt];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
